// File: rtl/uart_cmd_seq.sv
// Command sequencer for a UART link: sends a 4-word header plus buffered
// payload on an AXI-stream master, then collects a fixed-length response.
module uart_cmd_seq #(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_PAYLOAD    = 16,
    parameter int RSP_WORDS      = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1,
    localparam int RW = (RSP_WORDS > 1) ? $clog2(RSP_WORDS) : 1,
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic [7:0]                      cmd_opcode_i,
    input  logic [7:0]                      cmd_nwords_i,
    input  logic                            pl_wr_en_i,
    input  logic [AW-1:0]                   pl_wr_addr_i,
    input  logic [DATA_WIDTH-1:0]           pl_wr_data_i,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata_o,
    output logic                            m_axis_tvalid_o,
    input  logic                            m_axis_tready_i,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata_i,
    input  logic                            s_axis_tvalid_i,
    output logic                            s_axis_tready_o,
    output logic [RSP_WORDS*DATA_WIDTH-1:0] rsp_data_o,
    output logic                            rsp_valid_o,
    output logic                            rsp_timeout_o,
    output logic                            busy_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_RESP    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [7:0] MAXP      = 8'(MAX_PAYLOAD);

    logic [2:0]                             state_q;
    logic [7:0]                             opcode_q;
    logic [7:0]                             nw_q;
    logic [7:0]                             idx_q;
    logic [RW-1:0]                          rcnt_q;
    logic [TW-1:0]                          tcnt_q;
    logic [RSP_WORDS-1:0][DATA_WIDTH-1:0]   rsp_q;
    logic [DATA_WIDTH-1:0]                  buffer [MAX_PAYLOAD];
    logic [15:0]                            len;
    logic [DATA_WIDTH-1:0]                  tx_word;
    logic                                   in_tx;
    logic                                   tmo_hit;

    assign len     = 16'd4 + {8'd0, nw_q};
    assign in_tx   = (state_q == S_HDR) || (state_q == S_PAYLOAD);
    // Counter holds idle cycles minus one, so the pulse lands on the
    // TIMEOUT_CYCLES-th idle cycle; a word in that same cycle suppresses it.
    assign tmo_hit = (state_q == S_RESP) && !s_axis_tvalid_i &&
                     (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tx_word = '0;
        if (state_q == S_HDR) begin
            case (idx_q[1:0])
                2'd0:    tx_word = DATA_WIDTH'(opcode_q);
                2'd1:    tx_word = '0;
                2'd2:    tx_word = DATA_WIDTH'(len[7:0]);
                default: tx_word = DATA_WIDTH'(len[15:8]);
            endcase
        end else if (state_q == S_PAYLOAD) begin
            tx_word = buffer[idx_q[AW-1:0]];
        end
    end

    assign m_axis_tvalid_o = in_tx && !rst;
    assign m_axis_tdata_o  = (in_tx && !rst) ? tx_word : '0;
    assign cmd_ready_o     = (state_q == S_IDLE) && !rst;
    assign busy_o          = (state_q != S_IDLE) && !rst;
    assign rsp_valid_o     = (state_q == S_DONE) && !rst;
    assign rsp_timeout_o   = tmo_hit && !rst;
    assign s_axis_tready_o = !rst;
    assign rsp_data_o      = rst ? '0 : rsp_q;

    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_IDLE) && pl_wr_en_i)
            buffer[pl_wr_addr_i] <= pl_wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            nw_q     <= '0;
            idx_q    <= '0;
            rcnt_q   <= '0;
            tcnt_q   <= '0;
            rsp_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid_i) begin
                    opcode_q <= cmd_opcode_i;
                    nw_q     <= (cmd_nwords_i > MAXP) ? MAXP : cmd_nwords_i;
                    idx_q    <= '0;
                    state_q  <= S_HDR;
                end
                S_HDR: if (m_axis_tready_i) begin
                    if (idx_q == 8'd3) begin
                        idx_q <= '0;
                        if (nw_q == 8'd0) begin
                            state_q <= S_RESP;
                            tcnt_q  <= '0;
                            rcnt_q  <= '0;
                            rsp_q   <= '0;
                        end else begin
                            state_q <= S_PAYLOAD;
                        end
                    end else begin
                        idx_q <= idx_q + 8'd1;
                    end
                end
                S_PAYLOAD: if (m_axis_tready_i) begin
                    if (idx_q == nw_q - 8'd1) begin
                        state_q <= S_RESP;
                        tcnt_q  <= '0;
                        rcnt_q  <= '0;
                        rsp_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 8'd1;
                    end
                end
                S_RESP: begin
                    if (s_axis_tvalid_i) begin
                        rsp_q[rcnt_q] <= s_axis_tdata_i;
                        tcnt_q        <= '0;
                        if (rcnt_q == RW'(RSP_WORDS - 1))
                            state_q <= S_DONE;
                        else
                            rcnt_q <= rcnt_q + 1'b1;
                    end else if (tmo_hit) begin
                        state_q <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Directed + randomized bench for uart_cmd_seq against a word-list reference
// model of the header/payload framing and response collection.
module tb_uart_cmd_seq;

    localparam int DW = 8;
    localparam int MP = 16;
    localparam int RW = 4;
    localparam int TO = 10;
    localparam int AW = 4;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_opcode;
    logic [7:0]        cmd_nwords;
    logic              pl_wr_en;
    logic [AW-1:0]     pl_wr_addr;
    logic [DW-1:0]     pl_wr_data;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [RW*DW-1:0]  rsp_data;
    logic              rsp_valid;
    logic              rsp_timeout;
    logic              busy;

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0]    model_buf [MP];
    logic [DW-1:0]    exp_q [$];
    logic [DW-1:0]    got_q [$];
    logic [RW*DW-1:0] exp_rsp;
    logic [RW*DW-1:0] last_rsp;

    uart_cmd_seq #(
        .DATA_WIDTH(DW), .MAX_PAYLOAD(MP), .RSP_WORDS(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_opcode_i(cmd_opcode), .cmd_nwords_i(cmd_nwords),
        .pl_wr_en_i(pl_wr_en), .pl_wr_addr_i(pl_wr_addr), .pl_wr_data_i(pl_wr_data),
        .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready),
        .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready),
        .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_timeout_o(rsp_timeout),
        .busy_o(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        cmd_valid = 1'b0; cmd_opcode = '0; cmd_nwords = '0;
        pl_wr_en = 1'b0; pl_wr_addr = '0; pl_wr_data = '0;
        s_tvalid = 1'b0; s_tdata = '0;
    endtask

    // Noise driven only while the block is busy: all of it must be ignored.
    task automatic junk();
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_opcode = 8'($urandom);
        cmd_nwords = 8'($urandom);
        pl_wr_en   = 1'($urandom_range(0, 1));
        pl_wr_addr = AW'($urandom);
        pl_wr_data = DW'($urandom);
        s_tvalid   = 1'($urandom_range(0, 1));
        s_tdata    = DW'($urandom);
    endtask

    task automatic load(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        quiet();
        pl_wr_en = 1'b1; pl_wr_addr = AW'(a); pl_wr_data = d;
        model_buf[a] = d;
        @(negedge clk);
        quiet();
    endtask

    task automatic load_all();
        for (int i = 0; i < MP; i++) load(i, DW'($urandom));
    endtask

    // mode 0: tready=1, mode 1: toggle 1/0, mode 2: random
    task automatic send_cmd(input logic [7:0] op, input logic [7:0] nw, input int mode);
        int n, cyc;
        logic [15:0] len;
        logic prev_stall;
        logic [DW-1:0] prev_data;
        n   = (int'(nw) > MP) ? MP : int'(nw);
        len = 16'(4 + n);
        exp_q = {};
        got_q = {};
        exp_q.push_back(op);
        exp_q.push_back('0);
        exp_q.push_back(len[7:0]);
        exp_q.push_back(len[15:8]);
        for (int i = 0; i < n; i++) exp_q.push_back(model_buf[i]);
        @(negedge clk);
        quiet();
        m_tready = 1'b1;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_nwords = nw;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        chk("rsp_hold", rsp_data, last_rsp);
        prev_stall = 1'b0;
        prev_data  = '0;
        cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < 8 * (n + 4) + 20) begin
            @(negedge clk);
            junk();
            m_tready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (cyc == 0) chk("first_hdr_valid", m_tvalid, 1);
            if (mode == 0) chk("no_gap", m_tvalid, 1);
            if (prev_stall) chk("stall_stable", m_tdata, prev_data);
            chk("busy_no_ready", cmd_ready, 0);
            if (m_tvalid && m_tready) got_q.push_back(m_tdata);
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            cyc++;
        end
        chk("tx_count", 64'(got_q.size()), 64'(exp_q.size()));
        if (mode == 0) chk("tx_cycles", 64'(cyc), 64'(n + 4));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("tx_word%0d", i), got_q[i], exp_q[i]);
    endtask

    // gapmode 1 puts each word on the very cycle the timeout would fire.
    task automatic respond(input int nw, input int gapmode, input bit fixed);
        int g, found;
        logic [DW-1:0] w;
        exp_rsp = '0;
        for (int k = 0; k < nw; k++) begin
            g = gapmode ? TO - 1 : $urandom_range(0, 3);
            for (int j = 0; j < g; j++) begin
                @(negedge clk);
                junk();
                s_tvalid = 1'b0;
                #1;
                if (k == 0 && j == 0) chk("rsp_clear", rsp_data, 0);
                chk("no_timeout_idle", rsp_timeout, 0);
            end
            @(negedge clk);
            junk();
            w = fixed ? DW'(8'hAA + 8'h11 * k) : DW'($urandom);
            s_tvalid = 1'b1; s_tdata = w;
            exp_rsp[k*DW +: DW] = w;
            #1;
            if (k == 0 && g == 0) chk("rsp_clear", rsp_data, 0);
            chk("no_timeout_word", rsp_timeout, 0);
        end
        if (nw == RW) begin
            @(negedge clk);
            quiet();
            #1;
            chk("rsp_valid_pulse", rsp_valid, 1);
            chk("rsp_data", rsp_data, exp_rsp);
            chk("done_busy", busy, 1);
            chk("done_no_timeout", rsp_timeout, 0);
            @(negedge clk);
            #1;
            chk("rsp_valid_end", rsp_valid, 0);
            chk("idle_busy", busy, 0);
            chk("rsp_data_hold", rsp_data, exp_rsp);
        end else begin
            found = 0;
            for (int j = 1; j <= TO + 5 && found == 0; j++) begin
                @(negedge clk);
                quiet();
                #1;
                chk("tmo_no_valid", rsp_valid, 0);
                if (rsp_timeout) found = j;
            end
            chk("timeout_latency", 64'(found), 64'(TO));
            @(negedge clk);
            #1;
            chk("tmo_pulse_end", rsp_timeout, 0);
            chk("tmo_idle", busy, 0);
            chk("tmo_ready", cmd_ready, 1);
            chk("tmo_no_valid_after", rsp_valid, 0);
            chk("tmo_rsp_hold", rsp_data, exp_rsp);
        end
        last_rsp = exp_rsp;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, cmd_ready, 0);
        chk({tag, "_tvalid"}, m_tvalid, 0);
        chk({tag, "_tdata"}, m_tdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_s_tready"}, s_tready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_tmo"}, rsp_timeout, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
    endtask

    initial begin
        int nw, rn;
        quiet();
        m_tready = 1'b1;
        rst = 1'b1;
        last_rsp = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        #1;
        chk("post_reset_ready", cmd_ready, 1);
        chk("post_reset_s_tready", s_tready, 1);
        chk("post_reset_busy", busy, 0);

        load_all();
        load(0, 8'h05);
        load(1, 8'h07);
        send_cmd(8'h10, 8'd2, 0);
        chk("basic_len_word", got_q[2], 8'h06);
        respond(RW, 0, 1'b0);

        send_cmd(8'h22, 8'd0, 0);
        respond(RW, 0, 1'b1);
        chk("fixed_rsp", last_rsp, 32'hDDCCBBAA);

        send_cmd(8'h33, 8'd2, 1);
        respond(RW, 1, 1'b0);

        send_cmd(8'h44, 8'd200, 2);
        chk("clamp_len_lo", got_q[2], 8'h14);
        respond(2, 0, 1'b0);

        // Reset in the middle of the third header word.
        @(negedge clk);
        quiet();
        cmd_valid = 1'b1; cmd_opcode = 8'h55; cmd_nwords = 8'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            quiet();
            m_tready = 1'b1;
        end
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        #1;
        chk_all_zero("mid_rst_next");
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_tvalid", m_tvalid, 0);
        last_rsp = '0;
        load_all();
        send_cmd(8'h66, 8'd3, 0);
        respond(RW, 0, 1'b0);

        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) load($urandom_range(0, MP - 1), DW'($urandom));
            nw = $urandom_range(0, 20);
            send_cmd(8'($urandom), 8'(nw), $urandom_range(0, 2));
            rn = ($urandom_range(0, 3) == 0) ? $urandom_range(1, RW - 1) : RW;
            respond(rn, $urandom_range(0, 1), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_seq.md
UART_CMD_SEQ -- requirements
Module: uart_cmd_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the AXI-stream word width in bits; legal range is 8 or more.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 16, giving the payload buffer depth in words; legal range is 1 to 255.
REQ-003 SHALL have parameter RSP_WORDS, default 4, giving the response words collected per command; legal range is 1 or more.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the maximum idle cycles allowed between response words; legal range is 1 or more.
REQ-005 SHALL run on one clock and use a synchronous, active-high reset; the two ports are named clk and rst.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_opcode_i  in  8  opcode.
- cmd_nwords_i  in  8  payload word count.
- pl_wr_en_i  in  1  payload buffer write enable.
- pl_wr_addr_i  in  $clog2(MAX_PAYLOAD)  payload buffer write address.
- pl_wr_data_i  in  DATA_WIDTH  payload buffer write data.
- m_axis_tdata_o  out  DATA_WIDTH  word to the UART transmitter.
- m_axis_tvalid_o  out  1  transmit word valid.
- m_axis_tready_i  in  1  transmitter ready.
- s_axis_tdata_i  in  DATA_WIDTH  word from the UART receiver.
- s_axis_tvalid_i  in  1  receive word valid.
- s_axis_tready_o  out  1  always 1 when not in reset.
- rsp_data_o  out  RSP_WORDS*DATA_WIDTH  response; word 0 in the LSBs.
- rsp_valid_o  out  1  one-cycle pulse when the response is complete.
- rsp_timeout_o  out  1  one-cycle pulse when the response has timed out.
- busy_o  out  1  high in every state except IDLE.

Function
REQ-007 SHALL implement the states IDLE, HDR, PAYLOAD, RESP and DONE.
REQ-008 In IDLE, cmd_ready_o SHALL be 1; when cmd_valid_i is also 1, the block SHALL latch the opcode and N = min(cmd_nwords_i, MAX_PAYLOAD), then move to HDR.
REQ-009 HDR SHALL send 4 words in order, each zero-extended to DATA_WIDTH: opcode, 0x00, L[7:0], L[15:8], where L = 4 + N.
REQ-010 PAYLOAD SHALL send buffer[0] through buffer[N-1] in order; when N = 0, the block SHALL go directly from HDR to RESP.
REQ-011 A word SHALL advance only on a cycle where m_axis_tvalid_o and m_axis_tready_i are both 1; m_axis_tdata_o SHALL stay stable while tvalid is high and tready is low; m_axis_tvalid_o SHALL be 0 outside HDR and PAYLOAD.
REQ-012 The first header word SHALL be valid in the cycle after command acceptance; with tready held at 1, one word SHALL be sent per cycle with no gaps between HDR and PAYLOAD.
REQ-013 RESP SHALL store the k-th received word (s_axis_tvalid_i high) into rsp_data_o word k; after RSP_WORDS words, the block SHALL go to DONE.
REQ-014 Received words that arrive outside RESP SHALL be accepted and discarded.
REQ-015 The timeout counter SHALL clear on entry to RESP and on each received word, and SHALL increment on every other RESP cycle.
REQ-016 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL pulse rsp_timeout_o for 1 cycle, go to IDLE, and leave rsp_valid_o at 0.
REQ-017 DONE SHALL pulse rsp_valid_o for 1 cycle, then return to IDLE; rsp_data_o SHALL hold its value until the next entry to RESP, where it clears to 0.
REQ-018 If a word arrives in the same cycle the timeout would fire, the word SHALL win and the timeout SHALL NOT fire.
REQ-019 Payload writes SHALL take effect only in IDLE; writes while busy_o = 1 SHALL be ignored, and the buffer contents SHALL persist across commands.
REQ-020 cmd_valid_i while busy SHALL NOT be accepted and SHALL NOT be queued.

Reset
REQ-021 On rst = 1 at a clk edge:
- state SHALL go to IDLE and all counters SHALL clear;
- cmd_ready_o, m_axis_tvalid_o, rsp_valid_o, rsp_timeout_o and busy_o SHALL be 0 during reset;
- m_axis_tdata_o and rsp_data_o SHALL be 0;
- s_axis_tready_o SHALL be 0.
REQ-022 Reset asserted mid-command SHALL abort the command without a tvalid glitch; the payload buffer contents are unspecified after reset.
REQ-023 cmd_ready_o SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-024 Load buffer[0..1] = 0x05, 0x07; send opcode 0x10, N = 2, with tready = 1 -> transmitted words 0x10, 0x00, 0x06, 0x00, 0x05, 0x07 on consecutive cycles.
REQ-025 N = 0 with RSP_WORDS = 4; return words 0xAA, 0xBB, 0xCC, 0xDD -> rsp_data_o = 0xDDCCBBAA and rsp_valid_o pulses once.
REQ-026 Toggle tready 1/0 every cycle during a 6-word command -> the word sequence is identical to the no-stall case and tdata is stable during stalls.
REQ-027 TIMEOUT_CYCLES = 10 and only 2 response words are returned -> rsp_timeout_o pulses 10 cycles after the 2nd word, rsp_valid_o stays 0, and the block is in IDLE.
REQ-028 cmd_nwords_i = 200 with MAX_PAYLOAD = 16 -> L[7:0] = 0x14 and 16 payload words are sent.
REQ-029 Assert rst during the 3rd header word -> all outputs are 0 the next cycle, and a new command then sends correctly.
